// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - button pins in, debounced level and enable pulses out
interface button_conditioner_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] dpb;
  logic [N_BTN-1:0] scen;
  logic [N_BTN-1:0] mcen;
  logic [N_BTN-1:0] ccen;

  // Board/stimulus side: drives the raw buttons, consumes conditioned outputs
  modport master (
    output btn_raw,
    input  dpb,
    input  scen,
    input  mcen,
    input  ccen
  );

  // Conditioner side
  modport slave (
    input  btn_raw,
    output dpb,
    output scen,
    output mcen,
    output ccen
  );
endinterface

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - per-button synchroniser, debouncer and SCEN/MCEN/CCEN pulse generator
module button_conditioner #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter int CCEN_CYCLES     = 5000000
) (
  input  logic          clk,
  input  logic          reset,
  button_conditioner_if.slave bus
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int MC_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int MC_W   = $clog2(MC_MAX + 1);
  localparam int CC_W   = $clog2(CCEN_CYCLES + 1);

  // Terminal values: a counter reaching *_LAST on a qualifying edge completes the interval
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [MC_W-1:0] HOLD_LAST = MC_W'(HOLD_CYCLES - 1);
  localparam logic [MC_W-1:0] REP_LAST  = MC_W'(REPEAT_CYCLES - 1);
  localparam logic [CC_W-1:0] CC_LAST   = CC_W'(CCEN_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;

  // Two-flop synchroniser for the asynchronous board buttons
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.btn_raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    state_t          state_q;
    logic [DB_W-1:0] db_cnt_q;
    logic [MC_W-1:0] mc_cnt_q;
    logic            mc_rep_q;   // 0: waiting out the initial hold, 1: in repeat phase
    logic [CC_W-1:0] cc_cnt_q;
    logic            dpb_q;
    logic            scen_q;
    logic            mcen_q;
    logic            ccen_q;
    logic            sync_btn;

    assign sync_btn = sync2_q[g];

    // Channel FSM: debounce press/release, then run the repeat and continuous timers while held
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q  <= IDLE;
        db_cnt_q <= '0;
        mc_cnt_q <= '0;
        mc_rep_q <= 1'b0;
        cc_cnt_q <= '0;
        dpb_q    <= 1'b0;
        scen_q   <= 1'b0;
        mcen_q   <= 1'b0;
        ccen_q   <= 1'b0;
      end else begin
        scen_q <= 1'b0;
        mcen_q <= 1'b0;
        ccen_q <= 1'b0;
        case (state_q)
          IDLE: begin
            dpb_q <= 1'b0;
            if (sync_btn) begin
              state_q  <= PRESS_WAIT;
              db_cnt_q <= '0;
            end
          end
          PRESS_WAIT: begin
            if (!sync_btn) begin
              state_q <= IDLE;
            end else if (db_cnt_q == DB_LAST) begin
              // Accepted press: all three enables fire together with the dpb rise
              state_q  <= HELD;
              dpb_q    <= 1'b1;
              scen_q   <= 1'b1;
              mcen_q   <= 1'b1;
              ccen_q   <= 1'b1;
              mc_cnt_q <= '0;
              mc_rep_q <= 1'b0;
              cc_cnt_q <= '0;
            end else begin
              db_cnt_q <= db_cnt_q + DB_W'(1);
            end
          end
          HELD: begin
            dpb_q <= 1'b1;
            if (!sync_btn) begin
              state_q  <= RELEASE_WAIT;
              db_cnt_q <= '0;
            end else begin
              if ((!mc_rep_q && mc_cnt_q == HOLD_LAST) || (mc_rep_q && mc_cnt_q == REP_LAST)) begin
                mcen_q   <= 1'b1;
                mc_rep_q <= 1'b1;
                mc_cnt_q <= '0;
              end else begin
                mc_cnt_q <= mc_cnt_q + MC_W'(1);
              end
              if (cc_cnt_q == CC_LAST) begin
                ccen_q   <= 1'b1;
                cc_cnt_q <= '0;
              end else begin
                cc_cnt_q <= cc_cnt_q + CC_W'(1);
              end
            end
          end
          RELEASE_WAIT: begin
            if (sync_btn) begin
              // Release bounce: back to held with fresh timers, not a new press
              state_q  <= HELD;
              mc_cnt_q <= '0;
              mc_rep_q <= 1'b0;
              cc_cnt_q <= '0;
            end else if (db_cnt_q == DB_LAST) begin
              state_q <= IDLE;
              dpb_q   <= 1'b0;
            end else begin
              db_cnt_q <= db_cnt_q + DB_W'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            dpb_q   <= 1'b0;
          end
        endcase
      end
    end

    assign bus.dpb[g]  = dpb_q;
    assign bus.scen[g] = scen_q;
    assign bus.mcen[g] = mcen_q;
    assign bus.ccen[g] = ccen_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner
module tb_button_conditioner;

  typedef struct {
    int cyc;
    int ch;
    int kind;   // 0 scen, 1 mcen, 2 ccen
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];

  button_conditioner_if #(.N_BTN(4)) bus ();

  button_conditioner #(
    .N_BTN(4),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(20),
    .REPEAT_CYCLES(8),
    .CCEN_CYCLES(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Cycle n is the interval after the n-th rising edge
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kind_name(int k);
    return (k == 0) ? "scen" : (k == 1) ? "mcen" : "ccen";
  endfunction

  function automatic void push_ev(int kind, int ch, int c);
    ev_t e;
    e.cyc = c;
    e.ch = ch;
    e.kind = kind;
    exp_q.push_back(e);
  endfunction

  // Every observed pulse must match and consume one expected entry
  always @(negedge clk) begin
    logic bit_v;
    int   idx;
    for (int ch = 0; ch < 4; ch++) begin
      for (int kd = 0; kd < 3; kd++) begin
        bit_v = (kd == 0) ? bus.scen[ch] : (kd == 1) ? bus.mcen[ch] : bus.ccen[ch];
        if (bit_v !== 1'b0) begin
          idx = -1;
          for (int j = 0; j < exp_q.size(); j++)
            if (idx < 0 && exp_q[j].cyc == cyc && exp_q[j].ch == ch && exp_q[j].kind == kd) idx = j;
          checks++;
          if (idx < 0) begin
            errors++;
            $display("FAIL unexpected_pulse %s[%0d] at cycle %0d: got %b, expected 0", kind_name(kd), ch, cyc, bit_v);
          end else begin
            exp_q.delete(idx);
          end
        end
      end
    end
  end

  task automatic wait_cyc(int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.btn_raw = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.dpb !== 4'b0)  begin errors++; $display("FAIL reset_dpb got %b expected 0000", bus.dpb); end
    checks++; if (bus.scen !== 4'b0) begin errors++; $display("FAIL reset_scen got %b expected 0000", bus.scen); end
    checks++; if (bus.mcen !== 4'b0) begin errors++; $display("FAIL reset_mcen got %b expected 0000", bus.mcen); end
    checks++; if (bus.ccen !== 4'b0) begin errors++; $display("FAIL reset_ccen got %b expected 0000", bus.ccen); end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (bus.dpb !== 4'b0) begin errors++; $display("FAIL post_reset_dpb got %b expected 0000", bus.dpb); end
  endtask

  task automatic test_bounce;
    int b;
    b = cyc;
    bus.btn_raw[0] = 1'b1;
    wait_cyc(b + 3); bus.btn_raw[0] = 1'b0;
    wait_cyc(b + 6); bus.btn_raw[0] = 1'b1;
    wait_cyc(b + 8); bus.btn_raw[0] = 1'b0;
    for (int c = b + 1; c <= b + 20; c++) begin
      wait_cyc(c);
      checks++;
      if (bus.dpb[0] !== 1'b0) begin errors++; $display("FAIL bounce_dpb cycle %0d got %b expected 0", c, bus.dpb[0]); end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL bounce_missing got %0d unseen pulses expected 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_clean_press;
    int k, p;
    k = cyc + 2;
    p = k + 6;
    push_ev(0, 1, p);
    push_ev(1, 1, p);
    for (int n = 0; n <= 3; n++) push_ev(2, 1, p + 3 * n);
    wait_cyc(k - 1); bus.btn_raw[1] = 1'b1;
    wait_cyc(p - 1);
    checks++; if (bus.dpb[1] !== 1'b0) begin errors++; $display("FAIL clean_dpb_pre got %b expected 0", bus.dpb[1]); end
    wait_cyc(p);
    checks++; if (bus.dpb[1] !== 1'b1) begin errors++; $display("FAIL clean_dpb_rise got %b expected 1", bus.dpb[1]); end
    wait_cyc(p + 9); bus.btn_raw[1] = 1'b0;
    wait_cyc(p + 15);
    checks++; if (bus.dpb[1] !== 1'b1) begin errors++; $display("FAIL clean_dpb_hold got %b expected 1", bus.dpb[1]); end
    wait_cyc(p + 16);
    checks++; if (bus.dpb[1] !== 1'b0) begin errors++; $display("FAIL clean_dpb_fall got %b expected 0", bus.dpb[1]); end
    wait_cyc(p + 20);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL clean_missing got %0d unseen pulses (first %s cyc %0d) expected 0", exp_q.size(), kind_name(exp_q[0].kind), exp_q[0].cyc); exp_q.delete(); end
  endtask

  task automatic test_long_hold;
    int k, p;
    k = cyc + 2;
    p = k + 6;
    push_ev(0, 0, p);
    push_ev(1, 0, p);
    push_ev(1, 0, p + 20);
    push_ev(1, 0, p + 28);
    push_ev(1, 0, p + 36);
    push_ev(1, 0, p + 44);
    for (int n = 0; 3 * n <= 49; n++) push_ev(2, 0, p + 3 * n);
    wait_cyc(k - 1); bus.btn_raw[0] = 1'b1;
    wait_cyc(p + 47); bus.btn_raw[0] = 1'b0;
    wait_cyc(p + 53);
    checks++; if (bus.dpb[0] !== 1'b1) begin errors++; $display("FAIL long_dpb_hold got %b expected 1", bus.dpb[0]); end
    wait_cyc(p + 54);
    checks++; if (bus.dpb[0] !== 1'b0) begin errors++; $display("FAIL long_dpb_fall got %b expected 0", bus.dpb[0]); end
    wait_cyc(p + 58);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL long_missing got %0d unseen pulses (first %s cyc %0d) expected 0", exp_q.size(), kind_name(exp_q[0].kind), exp_q[0].cyc); exp_q.delete(); end
  endtask

  task automatic test_release_bounce;
    int k, p, e;
    k = cyc + 2;
    p = k + 6;
    e = p + 9;
    push_ev(0, 2, p);
    push_ev(1, 2, p);
    push_ev(2, 2, p);
    push_ev(2, 2, p + 3);
    push_ev(2, 2, p + 6);
    for (int n = 1; n <= 7; n++) push_ev(2, 2, e + 3 * n);
    push_ev(1, 2, e + 20);
    wait_cyc(k - 1); bus.btn_raw[2] = 1'b1;
    wait_cyc(p + 4); bus.btn_raw[2] = 1'b0;
    wait_cyc(p + 6); bus.btn_raw[2] = 1'b1;
    for (int c = p + 6; c <= e + 2; c++) begin
      wait_cyc(c);
      checks++;
      if (bus.dpb[2] !== 1'b1) begin errors++; $display("FAIL rbounce_dpb cycle %0d got %b expected 1", c, bus.dpb[2]); end
    end
    wait_cyc(e + 21); bus.btn_raw[2] = 1'b0;
    wait_cyc(e + 27);
    checks++; if (bus.dpb[2] !== 1'b1) begin errors++; $display("FAIL rbounce_dpb_hold got %b expected 1", bus.dpb[2]); end
    wait_cyc(e + 28);
    checks++; if (bus.dpb[2] !== 1'b0) begin errors++; $display("FAIL rbounce_dpb_fall got %b expected 0", bus.dpb[2]); end
    wait_cyc(e + 32);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rbounce_missing got %0d unseen pulses (first %s cyc %0d) expected 0", exp_q.size(), kind_name(exp_q[0].kind), exp_q[0].cyc); exp_q.delete(); end
  endtask

  task automatic test_simultaneous;
    int k, p;
    k = cyc + 2;
    p = k + 6;
    for (int ch = 0; ch < 4; ch++) begin
      push_ev(0, ch, p);
      push_ev(1, ch, p);
      push_ev(2, ch, p);
    end
    push_ev(2, 2, p + 3);
    for (int ch = 0; ch < 4; ch++) begin
      if (ch != 2) begin
        for (int n = 1; n <= 7; n++) push_ev(2, ch, p + 3 * n);
        push_ev(1, ch, p + 20);
      end
    end
    wait_cyc(k - 1); bus.btn_raw = 4'b1111;
    wait_cyc(p);
    checks++; if (bus.scen !== 4'b1111) begin errors++; $display("FAIL simul_scen got %b expected 1111", bus.scen); end
    wait_cyc(p + 3); bus.btn_raw[2] = 1'b0;
    wait_cyc(p + 10);
    checks++; if (bus.dpb !== 4'b1011) begin errors++; $display("FAIL simul_dpb_partial got %b expected 1011", bus.dpb); end
    wait_cyc(p + 21); bus.btn_raw = 4'b0000;
    wait_cyc(p + 27);
    checks++; if (bus.dpb !== 4'b1011) begin errors++; $display("FAIL simul_dpb_hold got %b expected 1011", bus.dpb); end
    wait_cyc(p + 28);
    checks++; if (bus.dpb !== 4'b0000) begin errors++; $display("FAIL simul_dpb_fall got %b expected 0000", bus.dpb); end
    wait_cyc(p + 32);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL simul_missing got %0d unseen pulses (first %s[%0d] cyc %0d) expected 0", exp_q.size(), kind_name(exp_q[0].kind), exp_q[0].ch, exp_q[0].cyc); exp_q.delete(); end
  endtask

  task automatic test_reset_mid_hold;
    int k, p, p2;
    k = cyc + 2;
    p = k + 6;
    push_ev(0, 3, p);
    push_ev(1, 3, p);
    push_ev(2, 3, p);
    wait_cyc(k - 1); bus.btn_raw[3] = 1'b1;
    wait_cyc(p + 2);
    @(posedge clk);
    #2;
    checks++; if (bus.ccen[3] !== 1'b1) begin errors++; $display("FAIL midrst_ccen_pre got %b expected 1", bus.ccen[3]); end
    checks++; if (bus.dpb[3] !== 1'b1)  begin errors++; $display("FAIL midrst_dpb_pre got %b expected 1", bus.dpb[3]); end
    reset = 1'b1;
    #1;
    checks++; if (bus.dpb !== 4'b0)  begin errors++; $display("FAIL midrst_dpb got %b expected 0000", bus.dpb); end
    checks++; if (bus.scen !== 4'b0) begin errors++; $display("FAIL midrst_scen got %b expected 0000", bus.scen); end
    checks++; if (bus.mcen !== 4'b0) begin errors++; $display("FAIL midrst_mcen got %b expected 0000", bus.mcen); end
    checks++; if (bus.ccen !== 4'b0) begin errors++; $display("FAIL midrst_ccen got %b expected 0000", bus.ccen); end
    wait_cyc(p + 5); reset = 1'b0;
    p2 = p + 12;
    push_ev(0, 3, p2);
    push_ev(1, 3, p2);
    push_ev(2, 3, p2);
    wait_cyc(p2 - 1);
    checks++; if (bus.dpb[3] !== 1'b0) begin errors++; $display("FAIL midrst_dpb_redebounce got %b expected 0", bus.dpb[3]); end
    wait_cyc(p2);
    checks++; if (bus.dpb[3] !== 1'b1) begin errors++; $display("FAIL midrst_dpb_repress got %b expected 1", bus.dpb[3]); end
    bus.btn_raw[3] = 1'b0;
    wait_cyc(p2 + 7);
    checks++; if (bus.dpb[3] !== 1'b0) begin errors++; $display("FAIL midrst_dpb_fall got %b expected 0", bus.dpb[3]); end
    wait_cyc(p2 + 11);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL midrst_missing got %0d unseen pulses (first %s cyc %0d) expected 0", exp_q.size(), kind_name(exp_q[0].kind), exp_q[0].cyc); exp_q.delete(); end
  endtask

  initial begin
    reset = 1'b1;
    bus.btn_raw = '0;
    test_reset;
    test_bounce;
    test_clean_press;
    test_long_hold;
    test_release_bounce;
    test_simultaneous;
    test_reset_mid_hold;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
